pcileech_board_ctl: RTL
=======================

// Module: pcileech_board_ctl
// PURPOSE
//  Board-level button/reset/LED controller for all PCILeech top modules, parametrised in button and LED count.
//  Debounces active-low user buttons and stretches a selected button into a held system reset (sys_rst) for fifo/com/pcie.
//  Drives each LED in a per-LED mode (off/on/blink/activity-stretch); replaces ad-hoc button/LED wiring in each top.
// PARAMETERS
//  NUM_BTN          2         number of user buttons (>=1)
//  NUM_LED          2         number of user LEDs (>=1)
//  RST_BTN_IDX      1         button index acting as system reset (< NUM_BTN)
//  DEBOUNCE_CYCLES  1000000   stable cycles needed to accept a button level change (>=1)
//  RST_HOLD_CYCLES  1024      sys_rst hold after all reset sources release (>=1)
//  BLINK_CYCLES     25000000  cycles per blink half-period (>=1)
//  ACT_STRETCH      5000000   cycles an LED stays lit after an activity pulse (>=1)
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          synchronous, active-low reset
//  btn_n      in   NUM_BTN    raw async buttons, active-low
//  btn_level  out  NUM_BTN    debounced level, 1 = pressed
//  btn_press  out  NUM_BTN    1-cycle pulse on accepted press edge
//  sys_rst    out  1          active-high system reset to downstream blocks
//  led_mode   in   2*NUM_LED  per-LED mode, 2 bits each (led_mode_t)
//  led_act    in   NUM_LED    activity strobes, 1 cycle each
//  led_out    out  NUM_LED    LED drive, 1 = lit
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): sync FFs=1 (released); btn_level=0; btn_press=0; debounce/blink/stretch counters=0;
//   sys_rst=1; hold counter loaded to RST_HOLD_CYCLES; led_out=0.
//  Debounce per button: 2-FF sync of btn_n, inverted; counter clears whenever synced value equals btn_level, else
//   increments; on reaching DEBOUNCE_CYCLES btn_level takes synced value and counter clears.
//   Latency raw edge -> btn_level = 2 + DEBOUNCE_CYCLES cycles. Glitch shorter than DEBOUNCE_CYCLES: no change.
//  btn_press[i]=1 exactly in the cycle btn_level[i] rises 0->1; never on release.
//  Reset FSM states: RST_ACTIVE (any source asserted), RST_HOLD (sources released, counting down), RUN.
//   Sources: rst_n=0, btn_level[RST_BTN_IDX]=1 (plus perst, see CONFIGURATION).
//   RST_ACTIVE->RST_HOLD when all sources release; RST_HOLD->RUN after RST_HOLD_CYCLES cycles;
//   any source in RST_HOLD or RUN -> RST_ACTIVE and reloads counter. sys_rst=1 in RST_ACTIVE/RST_HOLD, 0 only in RUN.
//  LED modes: 0 OFF led=0; 1 ON led=1; 2 BLINK led=shared blink phase, toggles every BLINK_CYCLES;
//   3 ACT led=1 while stretch counter!=0. led_act loads ACT_STRETCH (retriggers mid-stretch, counts in all modes).
//  led_out registered: reflects led_mode/counter one cycle later; mode change mid-blink uses current shared phase.
//  Counter widths $clog2(max+1); counters saturate, never wrap. Blink phase free-runs, ignores sys_rst, cleared only by rst_n.
// CONFIGURATION
//  PCILEECH_BOARD_CTL_PERST_EN defined: adds input pcie_perst_n (1, active-low, async) after led_act;
//   2-FF synced (reset value 1); synced low is an additional sys_rst source, no debounce.
//  Undefined: port absent; tops pass nothing; reset sources are rst_n and reset button only.
// STRUCTURE
//  pcileech_board_pkg: typedef enum logic[1:0] led_mode_t {LED_OFF,LED_ON,LED_BLINK,LED_ACT};
//   typedef enum rst_state_t {RST_ACTIVE,RST_HOLD,RUN}.
//  Sub-module pcileech_debounce (sync + counter + level + press edge), NUM_BTN instances via generate.
//  Reset FSM, blink divider, LED stretch counters inline in pcileech_board_ctl.
// TESTING (bench params: NUM_BTN=2, NUM_LED=2, RST_BTN_IDX=1, DEBOUNCE=4, RST_HOLD=8, BLINK=5, STRETCH=3)
//  1 rst_n low 3 cycles then high -> sys_rst=1 through 8 more cycles after the cycle rst_n releases, then 0; led_out=0, btn_level=0.
//  2 btn_n[0] low 3 cycles then high -> btn_level[0] stays 0, btn_press never pulses.
//  3 btn_n[0] held low -> btn_level[0]=1 at edge+6, btn_press[0] single 1-cycle pulse; release -> level 0 at +6, no pulse.
//  4 btn_n[1] held low 20 cycles in RUN -> sys_rst=1 from level rise until 8 cycles after level falls; re-press during hold restarts.
//  5 led_mode={ACT,BLINK}: led_out[0] toggles every 5 cycles; led_act[1] pulses at t, t+2 -> led_out[1]=1 from t+1 to t+5.
//  6 PERST_EN build: pcie_perst_n low 1 cycle in RUN -> sys_rst=1 from sync (+2) then 8-cycle hold; non-EN build compiles without port.

Source files
------------

// File: rtl/pcileech_board_pkg.sv
// Shared types for the PCILeech board controller: LED drive modes, reset FSM states
// and the counter-width helper used by every saturating counter.
package pcileech_board_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_ACT   = 2'd3
    } led_mode_t;

    typedef enum logic [1:0] {
        RST_ACTIVE = 2'd0,
        RST_HOLD   = 2'd1,
        RUN        = 2'd2
    } rst_state_t;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pcileech_debounce.sv
// Single-button debouncer: 2-FF synchroniser on the active-low pin, stability counter,
// debounced level (1 = pressed) and a one-cycle pulse on each accepted press.
module pcileech_debounce
    import pcileech_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_press
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          pressed;

    assign pressed = ~sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            sync1     <= btn_n;
            sync2     <= sync1;
            btn_press <= 1'b0;
            if (pressed == btn_level) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                // Final mismatching cycle: accept the new level; pulse only on press.
                btn_level <= pressed;
                btn_press <= pressed;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pcileech_board_ctl.sv
// Board button/reset/LED controller: debounced buttons, held system reset, per-LED modes.
// Optional macro PCILEECH_BOARD_CTL_PERST_EN adds pcie_perst_n as an extra reset source.
module pcileech_board_ctl
    import pcileech_board_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned NUM_LED         = 2,
    parameter int unsigned RST_BTN_IDX     = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RST_HOLD_CYCLES = 1024,
    parameter int unsigned BLINK_CYCLES    = 25000000,
    parameter int unsigned ACT_STRETCH     = 5000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BTN-1:0]   btn_n,
    output logic [NUM_BTN-1:0]   btn_level,
    output logic [NUM_BTN-1:0]   btn_press,
    output logic                 sys_rst,
    input  logic [2*NUM_LED-1:0] led_mode,
    input  logic [NUM_LED-1:0]   led_act,
`ifdef PCILEECH_BOARD_CTL_PERST_EN
    input  logic                 pcie_perst_n,
`endif
    output logic [NUM_LED-1:0]   led_out
);

    localparam int unsigned HW = cnt_width(RST_HOLD_CYCLES);
    localparam int unsigned BW = cnt_width(BLINK_CYCLES);
    localparam int unsigned SW = cnt_width(ACT_STRETCH);

    localparam logic [HW-1:0] HOLD_LOAD    = HW'(RST_HOLD_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(ACT_STRETCH);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        pcileech_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_n     (btn_n[i]),
            .btn_level (btn_level[i]),
            .btn_press (btn_press[i])
        );
    end

    logic perst_src;
`ifdef PCILEECH_BOARD_CTL_PERST_EN
    logic perst_sync1;
    logic perst_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perst_sync1 <= 1'b1;
            perst_sync2 <= 1'b1;
        end else begin
            perst_sync1 <= pcie_perst_n;
            perst_sync2 <= perst_sync1;
        end
    end
    assign perst_src = ~perst_sync2;
`else
    assign perst_src = 1'b0;
`endif

    logic rst_src;
    assign rst_src = btn_level[RST_BTN_IDX] | perst_src;

    rst_state_t    rst_state;
    logic [HW-1:0] hold_cnt;

    // rst_n is itself a source, so the reset branch doubles as the RST_ACTIVE entry.
    always_ff @(posedge clk) begin
        if (!rst_n || rst_src) begin
            rst_state <= RST_ACTIVE;
            hold_cnt  <= HOLD_LOAD;
            sys_rst   <= 1'b1;
        end else begin
            case (rst_state)
                RST_ACTIVE: begin
                    rst_state <= RST_HOLD;
                    hold_cnt  <= HOLD_LOAD;
                    sys_rst   <= 1'b1;
                end
                RST_HOLD: begin
                    if (hold_cnt <= HW'(1)) begin
                        rst_state <= RUN;
                        sys_rst   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                        sys_rst  <= 1'b1;
                    end
                end
                RUN: begin
                    sys_rst <= 1'b0;
                end
                default: begin
                    rst_state <= RST_ACTIVE;
                    hold_cnt  <= HOLD_LOAD;
                    sys_rst   <= 1'b1;
                end
            endcase
        end
    end

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt >= BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    for (genvar i = 0; i < NUM_LED; i++) begin : g_led
        logic [SW-1:0] act_cnt;
        logic          led_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                act_cnt <= '0;
                led_q   <= 1'b0;
            end else begin
                if (led_act[i]) begin
                    act_cnt <= STRETCH_LOAD;
                end else if (act_cnt != '0) begin
                    act_cnt <= act_cnt - SW'(1);
                end
                case (led_mode_t'(led_mode[2*i +: 2]))
                    LED_OFF:   led_q <= 1'b0;
                    LED_ON:    led_q <= 1'b1;
                    LED_BLINK: led_q <= blink_phase;
                    LED_ACT:   led_q <= (act_cnt != '0);
                    default:   led_q <= 1'b0;
                endcase
            end
        end

        assign led_out[i] = led_q;
    end

endmodule
